load_store_unit: RTL and testbench

- Memory-stage load/store unit between the EX/MEM pipeline register and the word-addressed data memory.
- Accepts one request per handshake: lb/lbu/lh/lhu/lw/sb/sh/sw.
  - Drives the memory's MemRead/MemWrite/Address/WriteData.
  - Performs byte-lane extraction and sign/zero extension for loads.
  - Performs read-modify-write for sub-word stores, because data memory only writes full words.
- Returns one registered response per request; stalls the pipeline while busy.

---
 rtl/lsu_pkg.sv | 11 +
 rtl/lsu_byte_lane.sv | 50 +++++
 rtl/load_store_unit.sv | 149 ++++++++++++++
 tb/tb_load_store_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes and the control FSM states.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic {ST_IDLE, ST_RMW} lsu_state_e;

endpackage

// File: rtl/lsu_byte_lane.sv
// Big-endian byte-lane steering: load extraction with sign/zero extension and
// sub-word merge into an existing word for read-modify-write stores.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [31:0] ext_word,
  input  logic [1:0]  ext_addr,
  input  logic [1:0]  ext_size,
  input  logic        ext_unsigned,
  output logic [31:0] ext_data,
  input  logic [31:0] mrg_old,
  input  logic [31:0] mrg_wdata,
  input  logic [1:0]  mrg_addr,
  input  logic [1:0]  mrg_size,
  output logic [31:0] mrg_data
);

  logic [1:0]  ext_lane;
  logic [1:0]  mrg_lane;
  logic [7:0]  ext_byte;
  logic [15:0] ext_half;

  // Address 0 is the most significant byte, so the bit lane is inverted.
  assign ext_lane = 2'd3 - ext_addr;
  assign mrg_lane = 2'd3 - mrg_addr;
  assign ext_byte = ext_word[{ext_lane, 3'b000} +: 8];
  assign ext_half = ext_addr[1] ? ext_word[15:0] : ext_word[31:16];

  always_comb begin
    ext_data = ext_word;
    case (ext_size)
      SZ_BYTE: ext_data = {{24{~ext_unsigned & ext_byte[7]}}, ext_byte};
      SZ_HALF: ext_data = {{16{~ext_unsigned & ext_half[15]}}, ext_half};
      default: ext_data = ext_word;
    endcase
  end

  always_comb begin
    mrg_data = mrg_old;
    case (mrg_size)
      SZ_BYTE: mrg_data[{mrg_lane, 3'b000} +: 8] = mrg_wdata[7:0];
      SZ_HALF: begin
        if (mrg_addr[1]) mrg_data[15:0]  = mrg_wdata[15:0];
        else             mrg_data[31:16] = mrg_wdata[15:0];
      end
      default: mrg_data = mrg_old;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one request per handshake, registered response,
// read-modify-write for byte/half stores against a word-only data memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              stall,
  output logic              dm_MemRead,
  output logic              dm_MemWrite,
  output logic [ADDR_W-1:0] dm_Address,
  output logic [DATA_W-1:0] dm_WriteData,
  input  logic [DATA_W-1:0] dm_ReadData
);

  lsu_state_e        state_q, state_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [ADDR_W-1:0] rmw_addr_q, rmw_addr_d;
  logic [DATA_W-1:0] rmw_old_q, rmw_old_d;
  logic [DATA_W-1:0] rmw_wdata_q, rmw_wdata_d;
  logic [1:0]        rmw_lane_q, rmw_lane_d;
  logic [1:0]        rmw_size_q, rmw_size_d;

  logic              accept;
  logic              req_err;
  logic [ADDR_W-1:0] aligned_addr;
  logic [DATA_W-1:0] ext_data;
  logic [DATA_W-1:0] merged_word;

  assign req_ready    = rst_n && (state_q == ST_IDLE);
  assign accept       = req_valid && req_ready;
  assign stall        = req_valid && !req_ready;
  assign aligned_addr = {req_addr[ADDR_W-1:2], 2'b00};
  assign req_err      = (req_size == SZ_ILL)
                     || ((req_size == SZ_HALF) && req_addr[0])
                     || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

  lsu_byte_lane u_lane (
    .ext_word     (dm_ReadData),
    .ext_addr     (req_addr[1:0]),
    .ext_size     (req_size),
    .ext_unsigned (req_unsigned),
    .ext_data     (ext_data),
    .mrg_old      (rmw_old_q),
    .mrg_wdata    (rmw_wdata_q),
    .mrg_addr     (rmw_lane_q),
    .mrg_size     (rmw_size_q),
    .mrg_data     (merged_word)
  );

  always_comb begin
    state_d      = state_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = '0;
    rsp_err_d    = 1'b0;
    rmw_addr_d   = rmw_addr_q;
    rmw_old_d    = rmw_old_q;
    rmw_wdata_d  = rmw_wdata_q;
    rmw_lane_d   = rmw_lane_q;
    rmw_size_d   = rmw_size_q;
    dm_MemRead   = 1'b0;
    dm_MemWrite  = 1'b0;
    dm_Address   = '0;
    dm_WriteData = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_err) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (!req_write) begin
            dm_MemRead  = 1'b1;
            dm_Address  = aligned_addr;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = ext_data;
          end else if (req_size == SZ_WORD) begin
            dm_MemWrite  = 1'b1;
            dm_Address   = aligned_addr;
            dm_WriteData = req_wdata;
            rsp_valid_d  = 1'b1;
          end else begin
            // Sub-word store: capture the current word now, write the merge next cycle.
            dm_MemRead  = 1'b1;
            dm_Address  = aligned_addr;
            rmw_addr_d  = aligned_addr;
            rmw_old_d   = dm_ReadData;
            rmw_wdata_d = req_wdata;
            rmw_lane_d  = req_addr[1:0];
            rmw_size_d  = req_size;
            state_d     = ST_RMW;
          end
        end
      end
      ST_RMW: begin
        // Gated by rst_n so a reset arriving mid-cycle kills the write before the edge.
        dm_MemWrite  = rst_n;
        dm_Address   = rmw_addr_q;
        dm_WriteData = merged_word;
        rsp_valid_d  = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rmw_addr_q  <= '0;
      rmw_old_q   <= '0;
      rmw_wdata_q <= '0;
      rmw_lane_q  <= '0;
      rmw_size_q  <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rmw_addr_q  <= rmw_addr_d;
      rmw_old_q   <= rmw_old_d;
      rmw_wdata_q <= rmw_wdata_d;
      rmw_lane_q  <= rmw_lane_d;
      rmw_size_q  <= rmw_size_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a small behavioural word memory.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        stall;
  logic        dm_MemRead;
  logic        dm_MemWrite;
  logic [31:0] dm_Address;
  logic [31:0] dm_WriteData;
  logic [31:0] dm_ReadData;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .stall(stall), .dm_MemRead(dm_MemRead),
    .dm_MemWrite(dm_MemWrite), .dm_Address(dm_Address),
    .dm_WriteData(dm_WriteData), .dm_ReadData(dm_ReadData)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:15] = '{4: 32'hA1B2C3D4, 5: 32'h80FF7F01, 6: 32'h11223344,
                              7: 32'h11223344, 8: 32'hCAFEF00D, default: 32'h0};
  assign dm_ReadData = mem[dm_Address[5:2]];
  always @(posedge clk) if (dm_MemWrite) mem[dm_Address[5:2]] <= dm_WriteData;

  typedef struct packed { logic [31:0] rdata; logic err; } exp_t;
  exp_t sb_q [$];

  int nchecks = 0;
  int nerrors = 0;
  logic done = 1'b0;

  logic        chk_dm = 1'b0, exp_rd = 1'b0, exp_wr = 1'b0, exp_stall = 1'b0;
  logic [31:0] exp_addr = '0, exp_wdata = '0;
  logic        chk_rspv = 1'b0, exp_rspv = 1'b0;
  logic        chk_mem = 1'b0;
  int          exp_mem_idx = 0;
  logic [31:0] exp_mem_val = '0;
  logic        chk_ready = 1'b0, exp_ready = 1'b0;
  logic        final_chk = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on every response.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rsp_err", 32'(rsp_err), 32'h0);
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_memread", 32'(dm_MemRead), 32'h0);
      chk("rst_memwrite", 32'(dm_MemWrite), 32'h0);
    end else if (rsp_valid) begin
      if (sb_q.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
    if (chk_dm) begin
      chk("dm_MemRead", 32'(dm_MemRead), 32'(exp_rd));
      chk("dm_MemWrite", 32'(dm_MemWrite), 32'(exp_wr));
      chk("stall", 32'(stall), 32'(exp_stall));
      if (exp_rd || exp_wr) chk("dm_Address", dm_Address, exp_addr);
      if (exp_wr || !exp_rd) chk("dm_WriteData", dm_WriteData, exp_wdata);
    end
    if (chk_rspv) chk("rsp_valid_timing", 32'(rsp_valid), 32'(exp_rspv));
    if (chk_mem) chk("mem_word", mem[exp_mem_idx], exp_mem_val);
    if (chk_ready) chk("req_ready", 32'(req_ready), 32'(exp_ready));
    if (final_chk) begin
      chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);
      done <= 1'b1;
    end
  end

  task automatic drive(input logic w, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
  endtask

  task automatic set_dm(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic st);
    chk_dm = 1'b1; exp_rd = rd; exp_wr = wr; exp_addr = a; exp_wdata = wd; exp_stall = st;
  endtask

  // Called at posedge+1 with the unit idle; returns at posedge+1 after the accept edge.
  task automatic issue(input logic w, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic erd, input logic ewr,
                       input logic [31:0] e_rdata, input logic e_err);
    exp_t e;
    drive(w, sz, uns, a, wd);
    set_dm(erd, ewr, {a[31:2], 2'b00}, ewr ? wd : 32'h0, 1'b0);
    chk_rspv = 1'b0;
    @(posedge clk);
    e.rdata = e_rdata; e.err = e_err;
    sb_q.push_back(e);
    #1;
  endtask

  task automatic idle_exp(input logic rspv);
    req_valid = 1'b0;
    set_dm(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk_rspv = 1'b1; exp_rspv = rspv;
    @(posedge clk); #1;
    chk_dm = 1'b0; chk_rspv = 1'b0;
  endtask

  initial begin
    exp_t e;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_exp(1'b0);

    // Word and sub-word loads, back to back.
    issue(0, SZ_WORD, 0, 32'h10, 0, 1, 0, 32'hA1B2C3D4, 0);
    idle_exp(1'b1);
    issue(0, SZ_BYTE, 0, 32'h15, 0, 1, 0, 32'hFFFFFFFF, 0);
    issue(0, SZ_BYTE, 1, 32'h15, 0, 1, 0, 32'h000000FF, 0);
    issue(0, SZ_HALF, 0, 32'h16, 0, 1, 0, 32'h00007F01, 0);
    issue(0, SZ_HALF, 0, 32'h14, 0, 1, 0, 32'hFFFF80FF, 0);
    issue(0, SZ_BYTE, 0, 32'h17, 0, 1, 0, 32'h00000001, 0);
    issue(0, SZ_BYTE, 1, 32'h14, 0, 1, 0, 32'h00000080, 0);
    idle_exp(1'b1);

    // sb 0x55 to 0x1A with a load of the same word queued behind it.
    drive(1, SZ_BYTE, 0, 32'h1A, 32'h55);
    set_dm(1, 0, 32'h18, 32'h0, 0);
    chk_rspv = 1'b0;
    @(posedge clk);
    e.rdata = 32'h0; e.err = 1'b0; sb_q.push_back(e);
    #1;
    drive(0, SZ_WORD, 0, 32'h18, 0);
    set_dm(0, 1, 32'h18, 32'h11225544, 1);
    chk_rspv = 1'b1; exp_rspv = 1'b0;
    @(posedge clk); #1;
    set_dm(1, 0, 32'h18, 32'h0, 0);
    exp_rspv = 1'b1;
    chk_mem = 1'b1; exp_mem_idx = 6; exp_mem_val = 32'h11225544;
    @(posedge clk);
    e.rdata = 32'h11225544; e.err = 1'b0; sb_q.push_back(e);
    #1 chk_mem = 1'b0;
    idle_exp(1'b1);

    // sh 0xBEEF to 0x1C.
    drive(1, SZ_HALF, 0, 32'h1C, 32'h0000BEEF);
    set_dm(1, 0, 32'h1C, 32'h0, 0);
    @(posedge clk);
    e.rdata = 32'h0; e.err = 1'b0; sb_q.push_back(e);
    #1 req_valid = 1'b0;
    set_dm(0, 1, 32'h1C, 32'hBEEF3344, 0);
    chk_rspv = 1'b1; exp_rspv = 1'b0;
    @(posedge clk); #1;
    chk_mem = 1'b1; exp_mem_idx = 7; exp_mem_val = 32'hBEEF3344;
    idle_exp(1'b1);
    chk_mem = 1'b0;

    // Misaligned and illegal-size requests: no memory traffic.
    issue(0, SZ_WORD, 0, 32'h12, 0, 0, 0, 32'h0, 1);
    issue(0, SZ_HALF, 0, 32'h11, 0, 0, 0, 32'h0, 1);
    issue(0, SZ_ILL,  0, 32'h10, 0, 0, 0, 32'h0, 1);
    issue(1, SZ_HALF, 0, 32'h13, 32'h1234, 0, 0, 32'h0, 1);
    idle_exp(1'b1);

    // sw then load back.
    issue(1, SZ_WORD, 0, 32'h24, 32'hDEADBEEF, 0, 1, 32'h0, 0);
    issue(0, SZ_WORD, 0, 32'h24, 0, 1, 0, 32'hDEADBEEF, 0);
    idle_exp(1'b1);

    // Reset during the RMW cycle of an sb: write and response must vanish.
    drive(1, SZ_BYTE, 0, 32'h21, 32'h99);
    set_dm(1, 0, 32'h20, 32'h0, 0);
    @(posedge clk); #1;
    req_valid = 1'b0; chk_dm = 1'b0;
    rst_n = 1'b0;
    chk_mem = 1'b1; exp_mem_idx = 8; exp_mem_val = 32'hCAFEF00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_ready = 1'b1; exp_ready = 1'b1;
    @(posedge clk); #1;
    chk_ready = 1'b0; chk_mem = 1'b0;
    issue(0, SZ_WORD, 0, 32'h20, 0, 1, 0, 32'hCAFEF00D, 0);
    idle_exp(1'b1);

    final_chk = 1'b1;
    for (int i = 0; i < 10 && !done; i++) @(posedge clk);
    #1;
    if (!done) begin
      $display("FAIL final_check: monitor did not complete, errors=%0d", nerrors);
      $fatal(1, "bench did not complete");
    end
    $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
    $finish;
  end

endmodule
